// File: rtl/wb_pkg.sv
// Shared write-back encodings and register-address width for the
// register-file write-port arbiter and its load FIFO.
package wb_pkg;

  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10,
    WB_ILL = 2'b11
  } wbsel_e;

  // Only the ALU and link selections carry a value from the ALU side.
  function automatic logic sel_writes(input wbsel_e s);
    return (s == WB_ALU) || (s == WB_PC4);
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Load-return buffer holding {rd, data}; exposes per-entry rd and occupancy
// so the arbiter can detect write-after-write hazards against ALU results.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  reg_addr_t             push_rd,
  input  logic [XLEN-1:0]       push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output reg_addr_t             head_rd,
  output logic [XLEN-1:0]       head_data,
  output logic [DEPTH-1:0]      occ,
  output reg_addr_t [DEPTH-1:0] ent_rd
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  reg_addr_t       mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_rd   = mem_rd[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    logic [AW-1:0] off;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off       = AW'(i) - rd_ptr;
      occ[i]    = ({1'b0, off} < count);
      ent_rd[i] = mem_rd[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= push_rd;
      mem_data[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the in-order ALU/jump path and
// buffered load returns, with WAW ordering and a bounded load-starvation age.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int LBUF_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [1:0]      WBSel,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] Wr_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            sel_err
);

  localparam int AGE_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    if (a >= AGE_W'(MAX_WAIT)) return AGE_W'(MAX_WAIT);
    return a + 1'b1;
  endfunction

  logic                      full;
  logic                      empty;
  reg_addr_t                 head_rd;
  logic [XLEN-1:0]           head_data;
  logic [LBUF_DEPTH-1:0]     occ;
  reg_addr_t [LBUF_DEPTH-1:0] ent_rd;
  logic                      push;
  logic                      haz_any;
  logic                      haz;
  logic                      gnt_ld;
  logic                      gnt_alu;
  logic [AGE_W-1:0]          age;
  wbsel_e                    sel;
  logic                      alu_we;
  logic [XLEN-1:0]           alu_wdata;

  // ld_ready comes from the registered count only, so a same-cycle pop
  // never reopens a full buffer.
  assign ld_ready = !full;
  assign push     = ld_valid && ld_ready;

  wb_load_fifo #(
    .XLEN  (XLEN),
    .DEPTH (LBUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (ld_rd),
    .push_data (Wr_data),
    .pop       (gnt_ld),
    .full      (full),
    .empty     (empty),
    .head_rd   (head_rd),
    .head_data (head_data),
    .occ       (occ),
    .ent_rd    (ent_rd)
  );

  always_comb begin
    haz_any = 1'b0;
    for (int i = 0; i < LBUF_DEPTH; i++) begin
      if (occ[i] && (ent_rd[i] == alu_rd)) haz_any = 1'b1;
    end
  end

  assign haz = (alu_rd != '0) && haz_any;

  // The head wins whenever letting the ALU go would reorder, overflow or
  // starve it; a load pushed this cycle is not yet visible in the count.
  assign gnt_ld    = !empty && (!alu_valid || haz || full || (age == AGE_W'(MAX_WAIT)));
  assign gnt_alu   = alu_valid && !gnt_ld;
  assign alu_ready = gnt_alu;

  assign sel    = wbsel_e'(WBSel);
  assign alu_we = sel_writes(sel) && (alu_rd != '0);

  always_comb begin
    case (sel)
      WB_PC4:  alu_wdata = pc_plus4;
      default: alu_wdata = alu_out;
    endcase
  end

  // Register-file write stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      sel_err  <= 1'b0;
      age      <= '0;
    end else begin
      if (gnt_ld) begin
        rf_we    <= (head_rd != '0);
        rf_waddr <= head_rd;
        rf_wdata <= head_data;
      end else if (gnt_alu) begin
        rf_we    <= alu_we;
        rf_waddr <= alu_rd;
        rf_wdata <= alu_wdata;
        if (!sel_writes(sel)) sel_err <= 1'b1;
      end else begin
        rf_we <= 1'b0;
      end

      if (empty || gnt_ld) age <= '0;
      else                 age <= age_sat_inc(age);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized check of the write-port arbiter against a
// queue-based reference of the grant, ordering and starvation rules.
module tb_wb_port_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int MW    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [1:0]      WBSel;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] pc_plus4;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] Wr_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            sel_err;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .XLEN       (XLEN),
    .LBUF_DEPTH (DEPTH),
    .MAX_WAIT   (MW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .WBSel     (WBSel),
    .alu_out   (alu_out),
    .pc_plus4  (pc_plus4),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .Wr_data   (Wr_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .sel_err   (sel_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_t;

  int          total = 0;
  int          bad   = 0;
  ld_t         q[$];
  int          m_age;
  bit          m_serr;
  bit          e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  bit          d_alu  = 0;
  bit          d_push = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_age  = 0;
    m_serr = 0;
    e_we   = 0;
    e_addr = '0;
    e_data = '0;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = '0; WBSel = 2'b01; alu_out = '0; pc_plus4 = '0;
    ld_valid  = 0; ld_rd  = '0; Wr_data = '0;
  endtask

  // One clock: check handshake outputs before the edge, then the write after it.
  task automatic step();
    bit  full, haz, take_ld, take_alu, was_empty;
    ld_t e;
    #1;
    full = (q.size() == DEPTH);
    haz  = 0;
    if (alu_rd != 0) foreach (q[i]) if (q[i].rd == alu_rd) haz = 1;
    take_ld  = (q.size() > 0) && (!alu_valid || haz || full || m_age == MW);
    take_alu = alu_valid && !take_ld;
    chk("ld_ready", ld_ready, !full);
    chk("alu_ready", alu_ready, take_alu);
    d_alu  = take_alu;
    d_push = ld_valid && !full;
    was_empty = (q.size() == 0);
    @(posedge clk);
    #1;
    if (was_empty || take_ld) m_age = 0;
    else m_age = (m_age < MW) ? m_age + 1 : MW;
    e_we = 0;
    if (take_ld) begin
      e = q.pop_front();
      e_we = (e.rd != 0); e_addr = e.rd; e_data = e.data;
    end else if (take_alu) begin
      if (WBSel == 2'b01) begin
        e_we = (alu_rd != 0); e_addr = alu_rd; e_data = alu_out;
      end else if (WBSel == 2'b10) begin
        e_we = (alu_rd != 0); e_addr = alu_rd; e_data = pc_plus4;
      end else begin
        m_serr = 1;
      end
    end
    if (d_push) q.push_back('{ld_rd, Wr_data});
    chk("rf_we", rf_we, e_we);
    if (e_we) begin
      chk("rf_waddr", rf_waddr, e_addr);
      chk("rf_wdata", rf_wdata, e_data);
    end
    chk("sel_err", sel_err, m_serr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    idle();
    model_reset();
    rst = 0;
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_ld_ready", ld_ready, 1);
    @(negedge clk); @(negedge clk);
    rst = 1;
    @(posedge clk); #1;

    // ALU-only traffic
    alu_valid = 1; alu_rd = 5'd3; WBSel = 2'b01; alu_out = 32'h4;
    step();
    chk("alu_wdata", rf_wdata, 32'h4);
    alu_rd = 5'd6; WBSel = 2'b10; pc_plus4 = 32'h8;
    step();
    chk("pc4_wdata", rf_wdata, 32'h8);

    // Load with ALU idle: two-cycle latency
    idle();
    ld_valid = 1; ld_rd = 5'd5; Wr_data = 32'hDEADBEEF;
    step();
    chk("ld_lat1_we", rf_we, 0);
    idle();
    step();
    chk("ld_waddr", rf_waddr, 5);
    chk("ld_wdata", rf_wdata, 32'hDEADBEEF);

    // WAW hazard: buffered load to x7 must land before the ALU write to x7
    ld_valid = 1; ld_rd = 5'd7; Wr_data = 32'h77;
    step();
    idle();
    alu_valid = 1; alu_rd = 5'd7; WBSel = 2'b01; alu_out = 32'h11;
    #1;
    chk("haz_alu_ready", alu_ready, 0);
    step();
    chk("haz_first", rf_wdata, 32'h77);
    step();
    chk("haz_second", rf_wdata, 32'h11);

    // Starvation bound with continuous ALU traffic to x1
    alu_rd = 5'd1; alu_out = 32'h100;
    ld_valid = 1; ld_rd = 5'd9; Wr_data = 32'h99;
    step();
    ld_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      alu_out = 32'h100 + 32'(k);
      step();
    end
    chk("starve_waddr", rf_waddr, 9);
    chk("starve_wdata", rf_wdata, 32'h99);
    chk("starve_age", 32'(dut.age), 0);

    // Full FIFO: two back-to-back loads, a third held until space opens
    alu_rd = 5'd2; alu_out = 32'h222;
    ld_valid = 1; ld_rd = 5'd10; Wr_data = 32'hA0;
    step();
    ld_rd = 5'd11; Wr_data = 32'hB0;
    step();
    ld_rd = 5'd12; Wr_data = 32'hC0;
    #1;
    chk("full_ld_ready", ld_ready, 0);
    step();
    chk("full_head_first", rf_waddr, 10);
    for (int k = 0; k < 4 && ld_valid; k++) begin
      step();
      if (d_push) ld_valid = 0;
    end
    alu_valid = 0;
    for (int k = 0; k < 4; k++) step();

    // Writes to x0 are consumed without a write
    idle();
    alu_valid = 1; alu_rd = 5'd0; alu_out = 32'h55;
    step();
    chk("x0_alu_we", rf_we, 0);
    idle();
    ld_valid = 1; ld_rd = 5'd0; Wr_data = 32'h66;
    step();
    idle();
    step();
    chk("x0_ld_we", rf_we, 0);

    // Illegal select is accepted, no write, sticky error
    alu_valid = 1; alu_rd = 5'd4; WBSel = 2'b11;
    step();
    chk("ill_sel_err", sel_err, 1);
    chk("ill_we", rf_we, 0);
    idle();
    step();
    chk("sticky_sel_err", sel_err, 1);

    // Reset with two loads buffered discards them
    alu_valid = 1; alu_rd = 5'd3; WBSel = 2'b01; alu_out = 32'h33;
    ld_valid = 1; ld_rd = 5'd13; Wr_data = 32'hD0;
    step();
    ld_rd = 5'd14; Wr_data = 32'hE0;
    step();
    idle();
    rst = 0;
    #1;
    chk("mid_rst_count", 32'(dut.u_fifo.count), 0);
    chk("mid_rst_ld_ready", ld_ready, 1);
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_sel_err", sel_err, 0);
    model_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) step();

    // Randomized traffic honouring the hold-while-stalled rule
    for (int n = 0; n < 400; n++) begin
      if (!(alu_valid && !d_alu)) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_rd    = 5'($urandom_range(0, 7));
        r         = int'($urandom_range(0, 19));
        WBSel     = (r < 9) ? 2'b01 : (r < 18) ? 2'b10 : (r == 18) ? 2'b00 : 2'b11;
        alu_out   = $urandom;
        pc_plus4  = $urandom;
      end
      if (!(ld_valid && !d_push)) begin
        ld_valid = ($urandom_range(0, 2) == 0);
        ld_rd    = 5'($urandom_range(0, 7));
        Wr_data  = $urandom;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
